// File: rtl/usb_frame_timer.sv
// USB frame timer: generates the SOF tick, the wrapping frame number, the in-frame cycle
// position and the end-of-frame guard flag. The period is trimmed at each frame start.
module usb_frame_timer #(
    parameter int CLK_PER_FRAME = 48000,
    parameter int FRAME_W       = 11,
    parameter int TRIM_W        = 8,
    parameter int EOF_GUARD     = 32,
    parameter int CNT_W         = $clog2(CLK_PER_FRAME + 2**(TRIM_W-1))
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_frame,
    input  logic [TRIM_W-1:0]  trim,
    output logic               sof_tick,
    output logic [FRAME_W-1:0] frame_num,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic               near_eof,
    output logic               running
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W:0] NOMINAL = (CNT_W+1)'(CLK_PER_FRAME);
    localparam logic [CNT_W:0] GUARD   = (CNT_W+1)'(EOF_GUARD);
    localparam logic [CNT_W:0] ONE     = (CNT_W+1)'(1);

    state_t             state_reg, state_next;
    logic               sof_reg, sof_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic [CNT_W-1:0]   cyc_reg, cyc_next;
    logic [CNT_W:0]     period_reg, period_next;
    logic [CNT_W:0]     trim_ext;
    logic [CNT_W:0]     period_trimmed;
    logic               frame_end;

    // Sign-extend the trim to the one-bit-wider period arithmetic width.
    genvar gi;
    generate
        for (gi = 0; gi <= CNT_W; gi++) begin : g_trim_sext
            if (gi < TRIM_W) begin : g_low
                assign trim_ext[gi] = trim[gi];
            end else begin : g_high
                assign trim_ext[gi] = trim[TRIM_W-1];
            end
        end
    endgenerate

    assign period_trimmed = NOMINAL + trim_ext;
    assign frame_end      = ({1'b0, cyc_reg} == period_reg - ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            sof_reg    <= 1'b0;
            frame_reg  <= '0;
            cyc_reg    <= '0;
            period_reg <= NOMINAL;
        end else begin
            state_reg  <= state_next;
            sof_reg    <= sof_next;
            frame_reg  <= frame_next;
            cyc_reg    <= cyc_next;
            period_reg <= period_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sof_next    = 1'b0;
        frame_next  = frame_reg;
        cyc_next    = cyc_reg;
        period_next = period_reg;

        // A load overrides the increment, so a coincident SOF carries load_frame.
        if (load) begin
            frame_next = load_frame;
        end

        if (clr) begin
            state_next = IDLE;
            cyc_next   = '0;
            frame_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_next  = RUN;
                        sof_next    = 1'b1;
                        cyc_next    = '0;
                        period_next = period_trimmed;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (frame_end) begin
                            sof_next    = 1'b1;
                            cyc_next    = '0;
                            period_next = period_trimmed;
                            if (!load) begin
                                frame_next = frame_reg + 1'b1;
                            end
                        end else begin
                            cyc_next = cyc_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sof_tick  = sof_reg;
    assign frame_num = frame_reg;
    assign cyc_cnt   = cyc_reg;
    assign running   = (state_reg == RUN);
    // Decoded from registers only, so it holds its value while paused.
    assign near_eof  = (state_reg == RUN) && ({1'b0, cyc_reg} >= period_reg - GUARD);

endmodule

// File: tb/tb_usb_frame_timer.sv
// Bench for usb_frame_timer: directed scenarios followed by randomized traffic, all
// checked every cycle against a behavioural frame model.
module tb_usb_frame_timer;
    localparam int CPF = 10;
    localparam int FW  = 4;
    localparam int TW  = 4;
    localparam int EG  = 2;
    localparam int CW  = $clog2(CPF + 2**(TW-1));

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          clr;
    logic          load;
    logic [FW-1:0] load_frame;
    logic [TW-1:0] trim;
    logic          sof_tick;
    logic [FW-1:0] frame_num;
    logic [CW-1:0] cyc_cnt;
    logic          near_eof;
    logic          running;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_run;
    bit m_sof;
    int m_cyc;
    int m_frame;
    int m_per;

    usb_frame_timer #(
        .CLK_PER_FRAME(CPF),
        .FRAME_W      (FW),
        .TRIM_W       (TW),
        .EOF_GUARD    (EG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .load      (load),
        .load_frame(load_frame),
        .trim      (trim),
        .sof_tick  (sof_tick),
        .frame_num (frame_num),
        .cyc_cnt   (cyc_cnt),
        .near_eof  (near_eof),
        .running   (running)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int period_of(input logic [TW-1:0] t);
        return CPF + int'($signed(t));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_sof   = 1'b0;
        m_cyc   = 0;
        m_frame = 0;
        m_per   = CPF;
    endtask

    task automatic model_edge();
        if (clr) begin
            m_run   = 1'b0;
            m_cyc   = 0;
            m_frame = 0;
            m_sof   = 1'b0;
            return;
        end
        m_sof = 1'b0;
        if (!m_run) begin
            if (load) m_frame = int'(load_frame);
            if (en) begin
                m_run = 1'b1;
                m_cyc = 0;
                m_per = period_of(trim);
                m_sof = 1'b1;
            end
        end else if (en && m_cyc == m_per - 1) begin
            m_sof   = 1'b1;
            m_cyc   = 0;
            m_per   = period_of(trim);
            m_frame = load ? int'(load_frame) : (m_frame + 1) % (1 << FW);
        end else begin
            if (en) m_cyc++;
            if (load) m_frame = int'(load_frame);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":sof"},     32'(sof_tick),  32'(m_sof));
        chk({tag, ":frame"},   32'(frame_num), 32'(m_frame));
        chk({tag, ":cyc"},     32'(cyc_cnt),   32'(m_cyc));
        chk({tag, ":near"},    32'(near_eof),  32'(m_run && (m_cyc >= m_per - EG)));
        chk({tag, ":running"}, 32'(running),   32'(m_run));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic wait_cyc(input int target, input string tag);
        int n = 0;
        while (!(m_run && m_cyc == target) && n < 50) begin
            cycle(tag);
            n++;
        end
        chk({tag, ":reach"}, 32'(cyc_cnt), 32'(target));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_frame = '0; trim = '0;
        model_reset();

        // Reset held for three cycles, then one idle cycle
        repeat (3) cycle("reset");
        chk("reset_running", 32'(running), 32'd0);
        reset = 1'b0;
        cycle("idle");

        // Start: first SOF carries frame 0, next SOF 10 cycles later with frame 1
        en = 1'b1;
        cycle("start");
        chk("start_sof", 32'(sof_tick), 32'd1);
        chk("start_frame", 32'(frame_num), 32'd0);
        repeat (8) cycle("frame0");
        chk("near_at_8", 32'(near_eof), 32'd1);
        cycle("frame0");
        chk("near_at_9", 32'(near_eof), 32'd1);
        cycle("sof1");
        chk("sof1_tick", 32'(sof_tick), 32'd1);
        chk("sof1_frame", 32'(frame_num), 32'd1);
        chk("sof1_near", 32'(near_eof), 32'd0);

        // Wrap: frame counter rolls 15 -> 0 on the 17th SOF
        repeat (150) cycle("wrap");
        chk("wrap_sof", 32'(sof_tick), 32'd1);
        chk("wrap_frame", 32'(frame_num), 32'd0);

        // Trim -3 mid-frame: current frame stays 10, following frames are 7
        repeat (3) cycle("pre_trim");
        trim = 4'hD;
        repeat (7) cycle("trim_cur");
        chk("trim_cur_sof", 32'(sof_tick), 32'd1);
        repeat (7) cycle("trim_7");
        chk("trim_7_sof", 32'(sof_tick), 32'd1);
        chk("trim_7_frame", 32'(frame_num), 32'd2);

        // Trim +5: the frame after the next SOF is 15 cycles, guard from 13
        trim = 4'd5;
        repeat (7) cycle("trim_7b");
        chk("trim_7b_sof", 32'(sof_tick), 32'd1);
        repeat (12) cycle("trim_15");
        chk("trim15_near12", 32'(near_eof), 32'd0);
        cycle("trim_15");
        chk("trim15_near13", 32'(near_eof), 32'd1);
        repeat (2) cycle("trim_15");
        chk("trim15_sof", 32'(sof_tick), 32'd1);

        // Pause for 5 cycles at cyc_cnt=4 in a 10-cycle frame
        trim = 4'd0;
        repeat (15) cycle("to_nominal");
        chk("nominal_sof", 32'(sof_tick), 32'd1);
        repeat (4) cycle("pre_pause");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("pause");
            chk("pause_cyc", 32'(cyc_cnt), 32'd4);
            chk("pause_sof", 32'(sof_tick), 32'd0);
        end
        en = 1'b1;
        repeat (5) cycle("resume");
        chk("resume_nosof", 32'(sof_tick), 32'd0);
        cycle("resume");
        chk("resume_sof", 32'(sof_tick), 32'd1);

        // Load on the wrap edge: SOF shows the loaded number
        repeat (9) cycle("pre_load");
        load = 1'b1; load_frame = 4'd9;
        cycle("load_wrap");
        chk("load_wrap_sof", 32'(sof_tick), 32'd1);
        chk("load_wrap_frame", 32'(frame_num), 32'd9);
        load = 1'b0;

        // Load mid-frame: number changes, cycle position keeps counting
        repeat (3) cycle("pre_load2");
        load = 1'b1; load_frame = 4'd3;
        cycle("load_mid");
        chk("load_mid_frame", 32'(frame_num), 32'd3);
        chk("load_mid_cyc", 32'(cyc_cnt), 32'd4);
        load = 1'b0;

        // clr beats load on the same edge
        clr = 1'b1; load = 1'b1; load_frame = 4'd7;
        cycle("clr_load");
        chk("clr_running", 32'(running), 32'd0);
        chk("clr_frame", 32'(frame_num), 32'd0);
        clr = 1'b0; load = 1'b0;

        // Asynchronous reset mid-frame, then restart
        cycle("restart");
        wait_cyc(6, "to_cyc6");
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_cyc", 32'(cyc_cnt), 32'd0);
        #1;
        reset = 1'b0;
        cycle("post_reset");
        chk("post_reset_sof", 32'(sof_tick), 32'd1);
        chk("post_reset_frame", 32'(frame_num), 32'd0);

        // Randomized traffic within the legal trim range
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            clr        = ($urandom_range(0, 79) == 0);
            load       = ($urandom_range(0, 29) == 0);
            load_frame = 4'($urandom);
            if ($urandom_range(0, 19) == 0) trim = 4'($urandom_range(10, 23));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
